spi_slave_fifo: RTL

SPI mode-0 target (slave) that answers the team's FIFO-fed SPI master: it oversamples `cs`/`sck`/`mosi` in the system clock domain, deserialises MOSI bytes into an RX FIFO, and serialises bytes popped from a TX FIFO onto MISO. It serves as the bench-side SPI device model in the SPI ROM test design and as an on-chip SPI target. It is byte-oriented and full-duplex, with no command decoding.

---
 rtl/spi_slave_fifo.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_fifo.sv
`timescale 1ns / 1ps
// spi_slave_fifo: SPI mode-0 target bridging a SPI master to a pair of byte FIFOs.
//
// cs/sck/mosi are synchronised into clk with 2-flop synchronisers. A further history flop
// on cs and sck gives edge detection. MOSI bytes (MSB first) are written to an RX FIFO.
// Bytes popped from a first-word-fall-through TX FIFO are shifted out on MISO.
// The block is full-duplex and byte-oriented, with no command decoding.
//
// Optional feature macro: SPI_SLAVE_ECHO_EN. When defined, a TX FIFO underrun at a byte
// boundary sends back the byte just received instead of FILL_BYTE. An underrun at LOAD
// always sends FILL_BYTE.
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   cs, sck, mosi  SPI inputs (asynchronous to clk); cs is active low; CPOL=0
//   miso           SPI serial output, MSB first; idles high
//   dout           received byte, valid while rx_fifo_wr=1
//   rx_fifo_wr     one-cycle RX FIFO write strobe; rx_fifo_full is the RX FIFO full flag
//   din            TX FIFO head, valid while tx_fifo_empty=0
//   tx_fifo_rd     one-cycle TX FIFO pop strobe
//   rx_overrun     sticky: a received byte was dropped because the RX FIFO was full
//   tx_underrun    sticky: a fill/echo byte was sent because the TX FIFO was empty
module spi_slave_fifo #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] dout,
  output logic       rx_fifo_wr,
  input  logic       rx_fifo_full,
  input  logic [7:0] din,
  input  logic       tx_fifo_empty,
  output logic       tx_fifo_rd,
  output logic       rx_overrun,
  output logic       tx_underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Synchronisers and edge-detect history
  logic cs_meta, cs_sync, cs_hist;
  logic sck_meta, sck_sync, sck_hist;
  logic mosi_meta, mosi_sync;

  // The cs flops reset low, so a reset taken while cs is held low does not look like a
  // fresh select. The master must raise and lower cs again.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      cs_hist   <= 1'b0;
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_hist  <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      cs_hist   <= cs_sync;
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_hist  <= sck_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  logic cs_fall, sck_rise, sck_fall;
  assign cs_fall  = cs_hist & ~cs_sync;
  assign sck_rise = ~sck_hist & sck_sync;
  assign sck_fall = sck_hist & ~sck_sync;

  logic [1:0] state_q, state_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] pend_q, pend_d;
  logic       byte_done_q, byte_done_d;  // at least one byte completed in this frame
  logic       miso_q, miso_d;
  logic [7:0] dout_q, dout_d;
  logic       rx_wr_q, rx_wr_d;
  logic       tx_rd_q, tx_rd_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       tx_und_q, tx_und_d;

  logic [7:0] rx_byte;
  logic [7:0] underrun_byte;
  assign rx_byte = {rx_sr_q[6:0], mosi_sync};
`ifdef SPI_SLAVE_ECHO_EN
  assign underrun_byte = rx_byte;
`else
  assign underrun_byte = FILL_BYTE;
`endif

  always_comb begin
    state_d     = state_q;
    bc_d        = bc_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    pend_d      = pend_q;
    byte_done_d = byte_done_q;
    miso_d      = miso_q;
    dout_d      = dout_q;
    rx_wr_d     = 1'b0;
    tx_rd_d     = 1'b0;
    rx_ovr_d    = rx_ovr_q;
    tx_und_d    = tx_und_q;

    case (state_q)
      ST_IDLE: begin
        miso_d      = 1'b1;
        bc_d        = 3'd0;
        byte_done_d = 1'b0;
        if (cs_fall) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // Flags clear first so the underrun check below can set tx_underrun again
        rx_ovr_d    = 1'b0;
        tx_und_d    = 1'b0;
        bc_d        = 3'd0;
        byte_done_d = 1'b0;
        if (!tx_fifo_empty) begin
          tx_sr_d = din;
          tx_rd_d = 1'b1;
        end else begin
          tx_sr_d  = FILL_BYTE;
          tx_und_d = 1'b1;
        end
        miso_d  = tx_sr_d[7];
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        // A deasserted cs level is checked, not only its rise. This also catches a cs rise
        // that arrived while the block was in LOAD. It wins over any sck edge.
        if (cs_sync) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b1;
          bc_d        = 3'd0;
          rx_sr_d     = 8'h00;
          pend_d      = 8'h00;
          byte_done_d = 1'b0;
        end else if (sck_rise) begin
          rx_sr_d = rx_byte;
          bc_d    = bc_q + 3'd1;
          if (bc_q == 3'd7) begin
            byte_done_d = 1'b1;
            dout_d      = rx_byte;
            if (!rx_fifo_full) rx_wr_d = 1'b1;
            else               rx_ovr_d = 1'b1;
            // Prefetch the next TX byte so it is ready for the boundary sck fall
            if (!tx_fifo_empty) begin
              pend_d  = din;
              tx_rd_d = 1'b1;
            end else begin
              pend_d   = underrun_byte;
              tx_und_d = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (bc_q == 3'd0 && byte_done_q) begin
            tx_sr_d = pend_q;
            miso_d  = pend_q[7];
          end else begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            miso_d  = tx_sr_q[6];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bc_q        <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      pend_q      <= 8'h00;
      byte_done_q <= 1'b0;
      miso_q      <= 1'b1;
      dout_q      <= 8'h00;
      rx_wr_q     <= 1'b0;
      tx_rd_q     <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_und_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bc_q        <= bc_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      pend_q      <= pend_d;
      byte_done_q <= byte_done_d;
      miso_q      <= miso_d;
      dout_q      <= dout_d;
      rx_wr_q     <= rx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_und_q    <= tx_und_d;
    end
  end

  assign miso        = miso_q;
  assign dout        = dout_q;
  assign rx_fifo_wr  = rx_wr_q;
  assign tx_fifo_rd  = tx_rd_q;
  assign rx_overrun  = rx_ovr_q;
  assign tx_underrun = tx_und_q;

endmodule
